// File: rtl/fsic_as_is_tx_buf.sv
// TX elastic buffer between the AXI-Stream switch and the serdes TX input, plus local flow-control bit.
// Optional FSIC_TX_BUF_PKT_CNT_EN adds a 16-bit count of popped tlast beats (tx_pkt_cnt).
module fsic_as_is_tx_buf #(
    parameter int pDATA_WIDTH   = 32,
    parameter int pDEPTH        = 4,
    parameter int pRX_FIFO_AW   = 3,
    parameter int pRX_THRESHOLD = 2
) (
    input  logic                     axis_clk,
    input  logic                     axis_rst_n,
    input  logic                     tx_en,
    input  logic [pDATA_WIDTH-1:0]   up_tdata,
    input  logic [pDATA_WIDTH/8-1:0] up_tstrb,
    input  logic [pDATA_WIDTH/8-1:0] up_tkeep,
    input  logic                     up_tlast,
    input  logic [1:0]               up_tid,
    input  logic [1:0]               up_tuser,
    input  logic                     up_tvalid,
    output logic                     up_tready,
    output logic [pDATA_WIDTH-1:0]   as_is_tdata,
    output logic [pDATA_WIDTH/8-1:0] as_is_tstrb,
    output logic [pDATA_WIDTH/8-1:0] as_is_tkeep,
    output logic                     as_is_tlast,
    output logic [1:0]               as_is_tid,
    output logic [1:0]               as_is_tuser,
    output logic                     as_is_tvalid,
    input  logic                     is_as_tready,
    input  logic [pRX_FIFO_AW-1:0]   rx_fifo_level,
`ifdef FSIC_TX_BUF_PKT_CNT_EN
    output logic [15:0]              tx_pkt_cnt,
`endif
    output logic                     as_is_tready
);
    localparam int PW = $clog2(pDEPTH);
    localparam int CW = $clog2(pDEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(pDEPTH);
    localparam logic [pRX_FIFO_AW-1:0] THR = pRX_FIFO_AW'(pRX_THRESHOLD);

    typedef struct packed {
        logic [pDATA_WIDTH-1:0]   tdata;
        logic [pDATA_WIDTH/8-1:0] tstrb;
        logic [pDATA_WIDTH/8-1:0] tkeep;
        logic                     tlast;
        logic [1:0]               tid;
        logic [1:0]               tuser;
    } beat_t;

    beat_t           mem [pDEPTH];
    beat_t           wr_beat;
    beat_t           head;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            alive;
    logic            push, pop;

    // alive keeps up_tready low while in reset and for the release cycle's edge
    assign up_tready    = alive & (count != FULL);
    assign as_is_tvalid = (count != '0) & tx_en;
    assign push         = up_tvalid & up_tready;
    assign pop          = as_is_tvalid & is_as_tready;

    assign wr_beat = '{tdata: up_tdata, tstrb: up_tstrb, tkeep: up_tkeep,
                       tlast: up_tlast, tid: up_tid, tuser: up_tuser};
    assign head    = mem[rd_ptr];

    assign as_is_tdata = head.tdata;
    assign as_is_tstrb = head.tstrb;
    assign as_is_tkeep = head.tkeep;
    assign as_is_tlast = head.tlast;
    assign as_is_tid   = head.tid;
    assign as_is_tuser = head.tuser;

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            for (int i = 0; i < pDEPTH; i++) mem[i] <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            alive        <= 1'b0;
            as_is_tready <= 1'b0;
        end else begin
            alive        <= 1'b1;
            as_is_tready <= (rx_fifo_level > THR);
            if (push) begin
                mem[wr_ptr] <= wr_beat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef FSIC_TX_BUF_PKT_CNT_EN
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n)              tx_pkt_cnt <= '0;
        else if (pop && head.tlast)   tx_pkt_cnt <= tx_pkt_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_fsic_as_is_tx_buf.sv
// Bench for fsic_as_is_tx_buf: queue-based reference model checked every negedge, plus directed literal checks.
module tb_fsic_as_is_tx_buf;
    localparam int DW = 32, DEPTH = 4, AW = 3, THR = 2;

    logic axis_clk = 1'b0, axis_rst_n = 1'b0, tx_en = 1'b0;
    logic [DW-1:0] up_tdata = '0;
    logic [DW/8-1:0] up_tstrb = '0, up_tkeep = '0;
    logic up_tlast = 1'b0, up_tvalid = 1'b0;
    logic [1:0] up_tid = '0, up_tuser = '0;
    logic up_tready;
    logic [DW-1:0] as_is_tdata;
    logic [DW/8-1:0] as_is_tstrb, as_is_tkeep;
    logic as_is_tlast, as_is_tvalid, is_as_tready = 1'b0, as_is_tready;
    logic [1:0] as_is_tid, as_is_tuser;
    logic [AW-1:0] rx_fifo_level = '0;
`ifdef FSIC_TX_BUF_PKT_CNT_EN
    logic [15:0] tx_pkt_cnt;
`endif

    fsic_as_is_tx_buf #(.pDATA_WIDTH(DW), .pDEPTH(DEPTH), .pRX_FIFO_AW(AW), .pRX_THRESHOLD(THR)) dut (
        .axis_clk(axis_clk), .axis_rst_n(axis_rst_n), .tx_en(tx_en),
        .up_tdata(up_tdata), .up_tstrb(up_tstrb), .up_tkeep(up_tkeep), .up_tlast(up_tlast),
        .up_tid(up_tid), .up_tuser(up_tuser), .up_tvalid(up_tvalid), .up_tready(up_tready),
        .as_is_tdata(as_is_tdata), .as_is_tstrb(as_is_tstrb), .as_is_tkeep(as_is_tkeep),
        .as_is_tlast(as_is_tlast), .as_is_tid(as_is_tid), .as_is_tuser(as_is_tuser),
        .as_is_tvalid(as_is_tvalid), .is_as_tready(is_as_tready), .rx_fifo_level(rx_fifo_level),
`ifdef FSIC_TX_BUF_PKT_CNT_EN
        .tx_pkt_cnt(tx_pkt_cnt),
`endif
        .as_is_tready(as_is_tready)
    );

    always #5 axis_clk = ~axis_clk;

    // Beat packed as {tdata, tstrb, tkeep, tlast, tid, tuser}
    typedef logic [DW+2*(DW/8)+4:0] beat_t;
    beat_t q[$];
    logic m_alive = 1'b0, m_rdy = 1'b0;
    logic [15:0] m_pkt = '0;
    int n_cmp = 0, n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic beat_t in_beat();
        return {up_tdata, up_tstrb, up_tkeep, up_tlast, up_tid, up_tuser};
    endfunction

    // Reference model: a plain queue, updated on each clock edge from the sampled inputs
    always @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            q.delete(); m_alive = 1'b0; m_rdy = 1'b0; m_pkt = '0;
        end else begin
            logic do_push, do_pop;
            do_push = up_tvalid && m_alive && (q.size() != DEPTH);
            do_pop  = tx_en && (q.size() != 0) && is_as_tready;
            if (do_pop) begin
                if (q[0][4]) m_pkt = m_pkt + 16'd1;
                void'(q.pop_front());
            end
            if (do_push) q.push_back(in_beat());
            m_rdy   = (rx_fifo_level > AW'(THR));
            m_alive = 1'b1;
        end
    end

    always @(negedge axis_clk) begin
        logic exp_vld;
        exp_vld = tx_en && (q.size() != 0);
        check("up_tready", 64'(up_tready), 64'(m_alive && (q.size() != DEPTH)));
        check("as_is_tvalid", 64'(as_is_tvalid), 64'(exp_vld));
        check("as_is_tready", 64'(as_is_tready), 64'(m_rdy));
        if (exp_vld)
            check("head_beat", 64'({as_is_tdata, as_is_tstrb, as_is_tkeep, as_is_tlast, as_is_tid, as_is_tuser}),
                  64'(q[0]));
`ifdef FSIC_TX_BUF_PKT_CNT_EN
        check("tx_pkt_cnt", 64'(tx_pkt_cnt), 64'(m_pkt));
`endif
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge axis_clk);
        #1;
    endtask

    task automatic set_beat(input logic [DW-1:0] d, input logic last, input logic [1:0] id, input logic [1:0] user);
        up_tdata = d; up_tstrb = '1; up_tkeep = '1; up_tlast = last; up_tid = id; up_tuser = user;
    endtask

    initial begin
        // reset values
        cyc(3);
        check("rst_up_tready", 64'(up_tready), 0);
        check("rst_tvalid", 64'(as_is_tvalid), 0);
        check("rst_tdata", 64'(as_is_tdata), 0);
        check("rst_as_is_tready", 64'(as_is_tready), 0);
        axis_rst_n = 1'b1;
        cyc();
        check("up_tready_after_rst", 64'(up_tready), 1);

        // in-order streaming, one cycle latency
        tx_en = 1'b1; is_as_tready = 1'b1; rx_fifo_level = 3'd3;
        for (int i = 0; i < 4; i++) begin
            up_tvalid = 1'b1; set_beat(32'h1111_1111 * (i + 1), 1'b0, 2'd0, 2'd0);
            cyc();
            check("stream_vld", 64'(as_is_tvalid), 1);
            check("stream_data", 64'(as_is_tdata), 64'(32'h1111_1111 * (i + 1)));
        end
        up_tvalid = 1'b0;
        cyc();
        check("stream_empty", 64'(as_is_tvalid), 0);

        // hold with tx_en=0, fill, then drain
        tx_en = 1'b0; up_tvalid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            set_beat(32'hA000_0000 + i, 1'b0, 2'd1, 2'd0);
            cyc();
        end
        set_beat(32'hA000_0005, 1'b0, 2'd1, 2'd0);
        check("full_up_tready", 64'(up_tready), 0);
        check("held_tvalid", 64'(as_is_tvalid), 0);
        tx_en = 1'b1; #1;
        check("drain_head1", 64'(as_is_tdata), 64'h A000_0001);
        cyc();
        check("drain_head2", 64'(as_is_tdata), 64'h A000_0002);
        check("drain_ready", 64'(up_tready), 1);
        cyc();
        up_tvalid = 1'b0;
        check("drain_head3", 64'(as_is_tdata), 64'h A000_0003);
        cyc(3);
        check("drain_done", 64'(as_is_tvalid), 0);

        // back-pressure: payload stable
        is_as_tready = 1'b0; up_tvalid = 1'b1; set_beat(32'hDEAD_BEEF, 1'b1, 2'd2, 2'd1);
        cyc();
        up_tvalid = 1'b0; set_beat(32'h0, 1'b0, 2'd0, 2'd0);
        for (int i = 0; i < 10; i++) begin
            check("hold_beat", 64'({as_is_tvalid, as_is_tdata, as_is_tlast, as_is_tid, as_is_tuser}),
                  64'({1'b1, 32'hDEAD_BEEF, 1'b1, 2'd2, 2'd1}));
            cyc();
        end
        is_as_tready = 1'b1;
        cyc();

        // steady push+pop at count=2 across pointer wrap
        is_as_tready = 1'b0; up_tvalid = 1'b1;
        for (int i = 0; i < 2; i++) begin set_beat(32'hC000_0000 + i, 1'b0, 2'd3, 2'd2); cyc(); end
        is_as_tready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            set_beat(32'hC000_0002 + k, 1'b0, 2'd3, 2'd2);
            check("pipe_head", 64'(as_is_tdata), 64'(32'hC000_0000 + k));
            cyc();
        end
        up_tvalid = 1'b0;
        cyc(2);
        check("pipe_empty", 64'(as_is_tvalid), 0);

        // flow-control threshold with one cycle latency
        rx_fifo_level = 3'd3; cyc();
        check("fc_lvl3", 64'(as_is_tready), 1);
        rx_fifo_level = 3'd2;
        check("fc_lvl2_before", 64'(as_is_tready), 1);
        cyc();
        check("fc_lvl2", 64'(as_is_tready), 0);
        rx_fifo_level = 3'd5; cyc();
        check("fc_lvl5", 64'(as_is_tready), 1);

        // async reset with beats queued
        is_as_tready = 1'b0; up_tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin set_beat(32'hB000_0000 + i, 1'b1, 2'd0, 2'd0); cyc(); end
        up_tvalid = 1'b0;
        check("pre_rst_vld", 64'(as_is_tvalid), 1);
        #2 axis_rst_n = 1'b0;
        #1;
        check("mid_rst_vld", 64'(as_is_tvalid), 0);
        check("mid_rst_rdy", 64'(up_tready), 0);
        cyc();
        axis_rst_n = 1'b1;
        cyc();
        check("post_rst_rdy", 64'(up_tready), 1);
        check("post_rst_vld", 64'(as_is_tvalid), 0);
        is_as_tready = 1'b1;

`ifdef FSIC_TX_BUF_PKT_CNT_EN
        // three 4-beat packets, then wrap from 0xFFFF
        up_tvalid = 1'b1;
        for (int i = 0; i < 12; i++) begin set_beat(32'(i), (i % 4) == 3, 2'd0, 2'd0); cyc(); end
        up_tvalid = 1'b0;
        cyc(2);
        check("pkt_cnt3", 64'(tx_pkt_cnt), 3);
        force dut.tx_pkt_cnt = 16'hFFFF;
        m_pkt = 16'hFFFF;
        cyc();
        release dut.tx_pkt_cnt;
        up_tvalid = 1'b1; set_beat(32'h5, 1'b1, 2'd0, 2'd0);
        cyc();
        up_tvalid = 1'b0;
        cyc(2);
        check("pkt_cnt_wrap", 64'(tx_pkt_cnt), 0);
`endif

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            up_tvalid     = ($urandom_range(0, 3) != 0);
            is_as_tready  = ($urandom_range(0, 2) != 0);
            tx_en         = ($urandom_range(0, 7) != 0);
            rx_fifo_level = AW'($urandom_range(0, 7));
            up_tdata = $urandom; up_tstrb = 4'($urandom); up_tkeep = 4'($urandom);
            up_tlast = 1'($urandom); up_tid = 2'($urandom); up_tuser = 2'($urandom);
            cyc();
        end
        up_tvalid = 1'b0;
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
